// File: rtl/rv32i_lsu_pkg.sv
// Shared definitions for the RV32I load/store unit: funct3 width codes,
// FSM state encoding, exception codes and the access fault classifier.
package rv32i_lsu_pkg;

  // funct3 access width/sign codes
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // LSU state encoding
  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_WAIT = 2'd2,
    LSU_DONE = 2'd3
  } lsu_state_e;

  // Exception codes reported during DONE
  localparam logic [1:0] LSU_EXC_NONE     = 2'b00;
  localparam logic [1:0] LSU_EXC_MISALIGN = 2'b01;
  localparam logic [1:0] LSU_EXC_TIMEOUT  = 2'b10;
  localparam logic [1:0] LSU_EXC_ILLEGAL  = 2'b11;

  // Classify an access before it reaches the bus. An illegal width
  // takes precedence over misalignment.
  function automatic logic [1:0] lsu_fault(input logic       is_store,
                                           input logic [2:0] f3,
                                           input logic [1:0] off);
    logic       legal;
    logic [1:0] code;
    if (is_store) begin
      legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    end else begin
      legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
              (f3 == F3_BU) || (f3 == F3_HU);
    end
    code = LSU_EXC_NONE;
    if (!legal) begin
      code = LSU_EXC_ILLEGAL;
    end else if ((f3[1:0] == 2'b01) && off[0]) begin
      code = LSU_EXC_MISALIGN;
    end else if ((f3[1:0] == 2'b10) && (off != 2'b00)) begin
      code = LSU_EXC_MISALIGN;
    end
    return code;
  endfunction

endpackage

// File: rtl/rv32i_load_align.sv
// Load data extraction: shifts the addressed byte/halfword down to bit 0
// and sign- or zero-extends it according to funct3.
module rv32i_load_align
  import rv32i_lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] word_i,
  output logic [31:0] data_o
);

  logic [31:0] shifted;

  assign shifted = word_i >> {offset_i, 3'b000};

  // Extend the low byte/halfword of the shifted word by access type
  always_comb begin
    data_o = shifted;
    case (funct3_i)
      F3_B:    data_o = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    data_o = {{16{shifted[15]}}, shifted[15:0]};
      F3_BU:   data_o = {24'h0, shifted[7:0]};
      F3_HU:   data_o = {16'h0, shifted[15:0]};
      default: data_o = shifted;
    endcase
  end

endmodule

// File: rtl/rv32i_lsu.sv
// MEM-stage load/store unit: single-outstanding request/response bus master
// with store lane steering, load extension, stall generation and exceptions.
module rv32i_lsu
  import rv32i_lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_mem_read_en,
  input  logic        i_mem_write_en,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_stall,
  output logic [31:0] o_rdata,
  output logic        o_rdata_valid,
  output logic [1:0]  o_exc,
  output logic        o_bus_req,
  output logic        o_bus_we,
  output logic [31:0] o_bus_addr,
  output logic [31:0] o_bus_wdata,
  output logic [3:0]  o_bus_wstrb,
  input  logic        i_bus_gnt,
  input  logic        i_bus_rvalid,
  input  logic [31:0] i_bus_rdata
);

  // Last count value before the access is abandoned
  localparam logic [9:0] TO_LAST = 10'(TIMEOUT_CYCLES - 1);

  lsu_state_e  state_q;
  logic [2:0]  funct3_q;
  logic [1:0]  off_q;
  logic [9:0]  cnt_q;
  logic        bus_req_q;
  logic        bus_we_q;
  logic [31:0] bus_addr_q;
  logic [31:0] bus_wdata_q;
  logic [3:0]  bus_wstrb_q;
  logic [31:0] rdata_q;
  logic        rdata_valid_q;
  logic [1:0]  exc_q;

  logic        access_d;
  logic        is_store_d;
  logic [1:0]  fault_d;
  logic [31:0] wdata_d;
  logic [3:0]  wstrb_d;
  logic [31:0] load_data_d;

  // A simultaneous read and write is treated as a load
  assign access_d   = i_mem_read_en | i_mem_write_en;
  assign is_store_d = i_mem_write_en & ~i_mem_read_en;
  assign fault_d    = lsu_fault(is_store_d, i_funct3, i_addr[1:0]);

  // Store lane replication and byte enables for the incoming access
  always_comb begin
    wdata_d = i_wdata;
    wstrb_d = 4'b1111;
    case (i_funct3[1:0])
      2'b00: begin
        wdata_d = {4{i_wdata[7:0]}};
        wstrb_d = 4'b0001 << i_addr[1:0];
      end
      2'b01: begin
        wdata_d = {2{i_wdata[15:0]}};
        wstrb_d = 4'b0011 << i_addr[1:0];
      end
      default: begin
        wdata_d = i_wdata;
        wstrb_d = 4'b1111;
      end
    endcase
  end

  rv32i_load_align u_align (
    .funct3_i (funct3_q),
    .offset_i (off_q),
    .word_i   (i_bus_rdata),
    .data_o   (load_data_d)
  );

  // Access sequencing, timeout counting and registered outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= LSU_IDLE;
      funct3_q      <= 3'b000;
      off_q         <= 2'b00;
      cnt_q         <= 10'd0;
      bus_req_q     <= 1'b0;
      bus_we_q      <= 1'b0;
      bus_addr_q    <= 32'h0;
      bus_wdata_q   <= 32'h0;
      bus_wstrb_q   <= 4'b0000;
      rdata_q       <= 32'h0;
      rdata_valid_q <= 1'b0;
      exc_q         <= LSU_EXC_NONE;
    end else begin
      case (state_q)
        LSU_IDLE: begin
          exc_q         <= LSU_EXC_NONE;
          rdata_valid_q <= 1'b0;
          if (access_d) begin
            funct3_q    <= i_funct3;
            off_q       <= i_addr[1:0];
            bus_we_q    <= is_store_d;
            bus_addr_q  <= {i_addr[31:2], 2'b00};
            bus_wdata_q <= wdata_d;
            bus_wstrb_q <= is_store_d ? wstrb_d : 4'b0000;
            cnt_q       <= 10'd0;
            if (fault_d != LSU_EXC_NONE) begin
              exc_q   <= fault_d;
              rdata_q <= 32'h0;
              state_q <= LSU_DONE;
            end else begin
              bus_req_q <= 1'b1;
              state_q   <= LSU_REQ;
            end
          end
        end
        LSU_REQ: begin
          if (i_bus_gnt) begin
            bus_req_q <= 1'b0;
            cnt_q     <= cnt_q + 10'd1;
            state_q   <= LSU_WAIT;
          end else if (cnt_q >= TO_LAST) begin
            bus_req_q <= 1'b0;
            exc_q     <= LSU_EXC_TIMEOUT;
            rdata_q   <= 32'h0;
            state_q   <= LSU_DONE;
          end else begin
            cnt_q <= cnt_q + 10'd1;
          end
        end
        LSU_WAIT: begin
          if (i_bus_rvalid) begin
            rdata_q       <= load_data_d;
            rdata_valid_q <= ~bus_we_q;
            exc_q         <= LSU_EXC_NONE;
            state_q       <= LSU_DONE;
          end else if (cnt_q >= TO_LAST) begin
            exc_q   <= LSU_EXC_TIMEOUT;
            rdata_q <= 32'h0;
            state_q <= LSU_DONE;
          end else begin
            cnt_q <= cnt_q + 10'd1;
          end
        end
        default: begin
          // DONE lasts one cycle; enables seen here belong to this access
          rdata_valid_q <= 1'b0;
          exc_q         <= LSU_EXC_NONE;
          state_q       <= LSU_IDLE;
        end
      endcase
    end
  end

  assign o_stall = ((state_q == LSU_IDLE) && access_d) ||
                   (state_q == LSU_REQ) || (state_q == LSU_WAIT);

  assign o_rdata       = rdata_q;
  assign o_rdata_valid = rdata_valid_q;
  assign o_exc         = exc_q;
  assign o_bus_req     = bus_req_q;
  assign o_bus_we      = bus_we_q;
  assign o_bus_addr    = bus_addr_q;
  assign o_bus_wdata   = bus_wdata_q;
  assign o_bus_wstrb   = bus_wstrb_q;

endmodule

// File: doc/rv32i_lsu.md
Name: rv32i_lsu

Overview:
- Load/store unit in the MEM stage. It consumes the memory enables, funct3 and ALU address produced by decode/EX, and drives a single-outstanding request/response data-bus master.
- It performs byte-lane steering, byte-enable generation and load sign/zero extension.
- It stalls the pipeline until each access completes, and reports misalignment, illegal width or bus timeout through an exception code.

Parameters:
- TIMEOUT_CYCLES, 255: cycles spent in REQ+WAIT before the access is aborted with a bus error. Legal range 1..1023.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- i_mem_read_en  in  1  MEM-stage load request
- i_mem_write_en  in  1  MEM-stage store request
- i_funct3  in  3  access width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- i_addr  in  32  effective byte address
- i_wdata  in  32  store data (rs2)
- o_stall  out  1  hold the pipeline
- o_rdata  out  32  extended load result, valid in the DONE cycle
- o_rdata_valid  out  1  one-cycle pulse in DONE for a successful load
- o_exc  out  2  exception code during DONE: 00 none, 01 misaligned, 10 bus timeout, 11 illegal funct3
- o_bus_req  out  1  request valid
- o_bus_we  out  1  1 = write
- o_bus_addr  out  32  word address, {addr[31:2],2'b00}
- o_bus_wdata  out  32  lane-replicated store data
- o_bus_wstrb  out  4  byte enables; 0000 on reads
- i_bus_gnt  in  1  request accepted this cycle
- i_bus_rvalid  in  1  response valid; loads and stores both get exactly one response
- i_bus_rdata  in  32  read word

Behaviour:
- FSM states IDLE, REQ, WAIT, DONE, encoded in 2 bits.
- Reset (asynchronous, immediate): state IDLE, o_bus_req 0, all bus outputs 0, o_rdata 0, o_rdata_valid 0, o_exc 00, timeout counter 0. Reset mid-transaction drops o_bus_req immediately; any later response is ignored.
- IDLE with (read|write) asserted:
  - o_stall=1 combinationally.
  - Latch funct3, addr[1:0], we, bus addr, wdata and wstrb.
  - Go to REQ; if a fault is detected, go directly to DONE with o_exc latched and no bus request issued.
- Read and write both asserted: the load is performed and the write is ignored.
- Fault checks:
  - funct3 ∉ {000,001,010,100,101} gives 11; for stores, only 000/001/010 are legal.
  - Otherwise, H/HU with addr[0]=1, or W with addr[1:0]≠00, gives 01.
- REQ: o_bus_req=1 with all bus fields held stable; o_stall=1. Go to WAIT when i_bus_gnt=1.
- WAIT: o_bus_req=0, o_stall=1. When i_bus_rvalid=1, register the extracted load data and go to DONE. i_bus_rvalid while in REQ is ignored.
- Timeout counter:
  - Clears on IDLE→REQ and increments each cycle in REQ or WAIT.
  - When the count reaches TIMEOUT_CYCLES-1 without completion, go to DONE with o_exc=10 and o_rdata=0.
  - In REQ the request is withdrawn.
- DONE:
  - o_stall=0 for exactly one cycle; o_rdata and o_exc are valid; o_rdata_valid=1 only for a load with o_exc=00.
  - The next state is always IDLE, even if the enables are high; those enables still belong to the completing instruction. o_exc returns to 00 in IDLE.
- Store lane steering:
  - SB: wdata={4{b}}, wstrb=0001<<addr[1:0].
  - SH: wdata={2{h}}, wstrb=0011<<addr[1:0].
  - SW: wdata unchanged, wstrb=1111.
- Load extraction: shift = i_bus_rdata >> (8*addr[1:0]). LB/LH sign-extend bit 7/15; LBU/LHU zero-extend; LW passes the word through.
- Minimum latency with gnt in REQ and rvalid on the first WAIT cycle: 3 stall cycles, DONE on cycle 3.

Decomposition:
- Shared decoder header: funct3 width codes, LSU state encoding, o_exc codes (LSU_EXC_NONE/MISALIGN/TIMEOUT/ILLEGAL).
- One combinational sub-module, rv32i_load_align: inputs funct3, byte offset and word; output 32-bit extended data. The FSM, counter and store steering stay in rv32i_lsu.

Test Plan:
- LW at 0x100, gnt in REQ, rvalid next cycle with rdata=0xDEADBEEF:
  - o_stall high 3 cycles; DONE o_rdata=0xDEADBEEF; o_rdata_valid=1; o_bus_addr=0x100; wstrb=0000.
- LB at 0x103 with rdata=0x80FF_1234 gives o_rdata=0xFFFFFF80. LBU on the same access gives 0x00000080. LHU at 0x102 gives 0x000080FF.
- SH at 0x202 with wdata=0x0000ABCD:
  - o_bus_we=1, o_bus_addr=0x200, wdata=0xABCDABCD, wstrb=1100.
  - DONE after rvalid; o_rdata_valid=0.
- Faults with no bus request issued:
  - LW at 0x101: o_bus_req never asserts; DONE on the cycle after IDLE with o_exc=01.
  - funct3=011 load: o_exc=11.
- TIMEOUT_CYCLES=8, gnt never asserted: o_bus_req high 8 cycles then drops; DONE with o_exc=10 and o_rdata=0.
- Reset and back-to-back:
  - Assert i_rst_n=0 in WAIT: o_stall and o_bus_req fall asynchronously. After release, a late rvalid produces no DONE.
  - Back-to-back loads with enables held through DONE: the second access starts from IDLE, and no request is issued in the DONE cycle.
